// File: rtl/sgemm_pkg.sv
// Shared widths and read-FSM encoding for the SGEMM C-result drain path.
package sgemm_pkg;

   localparam int ROW_W     = 256;
   localparam int OUT_W     = 512;
   localparam int CMP_W     = 10;
   localparam int RAM_DEPTH = 512;
   localparam int RAM_AW    = 9;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      CAP,
      HOLD
   } rd_state_e;

endpackage

// File: rtl/drain_ram_256x512.sv
// Per-row result buffer: simple dual-port RAM, 256b x 512, registered read.
module drain_ram_256x512
   import sgemm_pkg::*;
(
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [RAM_AW-1:0] i_wr_addr,
   input  logic [ROW_W-1:0]  i_wr_data,
   input  logic              i_rd_en,
   input  logic [RAM_AW-1:0] i_rd_addr,
   output logic [ROW_W-1:0]  o_rd_data
);

   logic [ROW_W-1:0] r_mem [RAM_DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
   end

endmodule

// File: rtl/drain_c_collector.sv
// Double-buffered collector for systolic-array C rows; drains each completed
// bank to the host as 512-bit words built from two consecutive row entries.
//
// state | meaning
// IDLE  | no undrained block, or waiting for one to complete
// RD_LO | read entry 2k of the current row/bank
// RD_HI | read entry 2k+1, capture low half
// CAP   | capture high half
// HOLD  | out_valid high until the host accepts
module drain_c_collector
   import sgemm_pkg::*;
#(
   parameter int NUM_ROWS      = 2,
   parameter int WORDS_PER_ROW = 256
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      wr_en,
   input  logic [NUM_ROWS*ROW_W-1:0] data_in,
   input  logic                      out_ready,
   output logic [OUT_W-1:0]          data_out,
   output logic                      out_valid,
   output logic                      c_available,
   output logic                      drain_c_full,
   output logic                      overflow_err
);

   localparam int CW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_ROW - 1);
   localparam logic [CW-1:0] LAST_PAIR = CW'(WORDS_PER_ROW - 2);
   localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);

   logic [CW-1:0]             r_wr_counter;
   logic                      r_wr_bank;
   logic [CMP_W-1:0]          r_wr_completed;
   logic [CMP_W-1:0]          r_rd_completed;
   logic                      r_overflow;
   logic                      r_ram_we;
   logic [RAM_AW-1:0]         r_ram_waddr;
   logic [NUM_ROWS*ROW_W-1:0] r_ram_wdata;

   logic [CMP_W-1:0]          w_occupancy;
   logic                      w_wr_accept;
   logic                      w_wr_last;

   rd_state_e                 r_state;
   rd_state_e                 w_state_nxt;
   logic [RW-1:0]             r_rd_row;
   logic [CW-1:0]             r_rd_word;
   logic                      r_rd_bank;
   logic [OUT_W-1:0]          r_data_out;

   logic                      w_rd_en;
   logic                      w_rd_hi;
   logic                      w_cap_lo;
   logic                      w_cap_hi;
   logic                      w_xfer;
   logic                      w_rd_last;
   logic [CW-1:0]             w_rd_word;
   logic [RAM_AW-1:0]         w_rd_addr;
   logic [ROW_W-1:0]          w_ram_q [NUM_ROWS];
   logic [ROW_W-1:0]          w_row_q;

   assign w_occupancy  = r_wr_completed - r_rd_completed;
   assign c_available  = (w_occupancy != '0);
   assign drain_c_full = (w_occupancy == CMP_W'(2));
   assign w_wr_accept  = wr_en && !drain_c_full;
   assign w_wr_last    = w_wr_accept && (r_wr_counter == LAST_WORD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_counter   <= '0;
         r_wr_bank      <= 1'b0;
         r_wr_completed <= '0;
         r_overflow     <= 1'b0;
         r_ram_we       <= 1'b0;
      end else begin
         r_ram_we <= w_wr_accept;
         if (wr_en && drain_c_full) r_overflow <= 1'b1;
         if (w_wr_last) begin
            r_wr_counter   <= '0;
            r_wr_bank      <= ~r_wr_bank;
            r_wr_completed <= r_wr_completed + CMP_W'(1);
         end else if (w_wr_accept) begin
            r_wr_counter <= r_wr_counter + CW'(1);
         end
      end
   end

   // Address and data need no reset: nothing is written while r_ram_we is low.
   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_ram_waddr <= RAM_AW'({r_wr_bank, r_wr_counter});
         r_ram_wdata <= data_in;
      end
   end

   assign w_rd_last = (r_rd_row == LAST_ROW) && (r_rd_word == LAST_PAIR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_rd_hi     = 1'b0;
      w_cap_lo    = 1'b0;
      w_cap_hi    = 1'b0;
      w_xfer      = 1'b0;
      case (r_state)
         IDLE: begin
            if (c_available) w_state_nxt = RD_LO;
         end
         RD_LO: begin
            w_rd_en     = 1'b1;
            w_state_nxt = RD_HI;
         end
         RD_HI: begin
            w_rd_en     = 1'b1;
            w_rd_hi     = 1'b1;
            w_cap_lo    = 1'b1;
            w_state_nxt = CAP;
         end
         CAP: begin
            w_cap_hi    = 1'b1;
            w_state_nxt = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               w_xfer      = 1'b1;
               w_state_nxt = w_rd_last ? IDLE : RD_LO;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_rd_word = r_rd_word | CW'(w_rd_hi);
   assign w_rd_addr = RAM_AW'({r_rd_bank, w_rd_word});
   assign w_row_q   = w_ram_q[r_rd_row];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out     <= '0;
         r_rd_row       <= '0;
         r_rd_word      <= '0;
         r_rd_bank      <= 1'b0;
         r_rd_completed <= '0;
      end else begin
         if (w_cap_lo) r_data_out[ROW_W-1:0]     <= w_row_q;
         if (w_cap_hi) r_data_out[OUT_W-1:ROW_W] <= w_row_q;
         if (w_xfer) begin
            if (w_rd_last) begin
               r_rd_row       <= '0;
               r_rd_word      <= '0;
               r_rd_bank      <= ~r_rd_bank;
               r_rd_completed <= r_rd_completed + CMP_W'(1);
            end else if (r_rd_word == LAST_PAIR) begin
               r_rd_word <= '0;
               r_rd_row  <= r_rd_row + RW'(1);
            end else begin
               r_rd_word <= r_rd_word + CW'(2);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
      drain_ram_256x512 u_ram (
         .clk       (clk),
         .i_wr_en   (r_ram_we),
         .i_wr_addr (r_ram_waddr),
         .i_wr_data (r_ram_wdata[g*ROW_W +: ROW_W]),
         .i_rd_en   (w_rd_en),
         .i_rd_addr (w_rd_addr),
         .o_rd_data (w_ram_q[g])
      );
   end

   assign data_out     = r_data_out;
   assign out_valid    = (r_state == HOLD);
   assign overflow_err = r_overflow;

endmodule

// File: tb/tb_drain_c_collector.sv
// Bench for drain_c_collector: block-level model of expected host words and
// occupancy, checked every cycle, plus directed scenario expectations.
module tb_drain_c_collector;

   localparam int NR  = 2;
   localparam int WPR = 256;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             wr_en = 1'b0;
   logic [NR*256-1:0] data_in = '0;
   logic             out_ready = 1'b0;
   logic [511:0]     data_out;
   logic             out_valid;
   logic             c_available;
   logic             drain_c_full;
   logic             overflow_err;

   drain_c_collector #(.NUM_ROWS(NR), .WORDS_PER_ROW(WPR)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .out_ready    (out_ready),
      .data_out     (data_out),
      .out_valid    (out_valid),
      .c_available  (c_available),
      .drain_c_full (drain_c_full),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [255:0] m_cur [NR][WPR];
   int           m_wc;
   int           m_blocks;
   bit           m_ovf;
   int           m_rd_words;
   logic [511:0] m_exp_q [$];
   logic [511:0] cap_q [$];
   bit           hold_prev;
   logic [511:0] prev_data;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model state reflects every clock edge so far; inputs seen here belong to the next edge.
   always @(negedge clk) begin
      bit drop;
      if (!reset_n) begin
         m_wc       = 0;
         m_blocks   = 0;
         m_ovf      = 0;
         m_rd_words = 0;
         m_exp_q.delete();
         hold_prev  = 0;
      end else begin
         check("c_available", c_available, m_blocks != 0);
         check("drain_c_full", drain_c_full, m_blocks == 2);
         check("overflow_err", overflow_err, m_ovf);
         if (hold_prev) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", data_out, prev_data);
         end
         if (out_valid && m_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_valid: out_valid=1 with no expected word");
         end
         drop      = (m_blocks == 2);
         hold_prev = out_valid && !out_ready;
         prev_data = data_out;
         if (out_valid && out_ready && m_exp_q.size() > 0) begin
            check("word", data_out, m_exp_q[0]);
            void'(m_exp_q.pop_front());
            cap_q.push_back(data_out);
            m_rd_words++;
            if (m_rd_words == NR*WPR/2) begin
               m_rd_words = 0;
               m_blocks--;
            end
         end
         if (wr_en) begin
            if (drop) begin
               m_ovf = 1;
            end else begin
               for (int r = 0; r < NR; r++) m_cur[r][m_wc] = data_in[r*256 +: 256];
               m_wc++;
               if (m_wc == WPR) begin
                  for (int r = 0; r < NR; r++)
                     for (int k = 0; k < WPR/2; k++)
                        m_exp_q.push_back({m_cur[r][2*k+1], m_cur[r][2*k]});
                  m_wc = 0;
                  m_blocks++;
               end
            end
         end
      end
   end

   task automatic drive_write(input logic [255:0] r0, input logic [255:0] r1);
      wr_en   = 1'b1;
      data_in = {r1, r0};
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int i = 0;
      while (!out_valid && i < 50) begin
         @(posedge clk); #1;
         i++;
      end
      n_tests++;
      if (!out_valid) begin
         n_fail++;
         $display("FAIL %s: out_valid=0 after 50 cycles, required 1", name);
      end
   endtask

   task automatic handshake_one(input string name);
      wait_valid(name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i = 0;
      while ((c_available || out_valid) && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      n_tests++;
      if (c_available || out_valid) begin
         n_fail++;
         $display("FAIL %s: still busy after %0d cycles (c_available=%0b out_valid=%0b)",
                  name, budget, c_available, out_valid);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_data_out", data_out, '0);
      check("rst_c_available", c_available, 1'b0);
      check("rst_drain_c_full", drain_c_full, 1'b0);
      check("rst_overflow", overflow_err, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // one block, host always ready
      cap_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < WPR; i++) drive_write(256'(i), 256'(1000 + i));
      wait_idle("s1_drain", 3000);
      check("s1_count", 512'(cap_q.size()), 512'(256));
      check("s1_word0", cap_q[0], {256'd1, 256'd0});
      check("s1_word127", cap_q[127], {256'd255, 256'd254});
      check("s1_word128", cap_q[128], {256'd1001, 256'd1000});
      check("s1_c_avail_after", c_available, 1'b0);

      // fill both banks with host stalled, then one extra write
      cap_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 2*WPR; i++) drive_write(256'(32'h20000 + i), 256'(32'h30000 + i));
      check("s2_full", drain_c_full, 1'b1);
      check("s2_no_ovf_yet", overflow_err, 1'b0);
      drive_write(256'hDEAD, 256'hBEEF);
      check("s2_overflow", overflow_err, 1'b1);
      check("s2_still_full", drain_c_full, 1'b1);
      out_ready = 1'b1;
      wait_idle("s2_drain", 6000);
      check("s2_count", 512'(cap_q.size()), 512'(512));
      check("s2_word256", cap_q[256], {256'(32'h20000 + 257), 256'(32'h20000 + 256)});
      check("s2_last", cap_q[511], {256'(32'h30000 + 511), 256'(32'h30000 + 510)});

      // random host backpressure
      cap_q.delete();
      for (int i = 0; i < 4000; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (i < WPR) begin
            wr_en   = 1'b1;
            data_in = {256'(7000 + i), 256'(5000 + i)};
         end else begin
            wr_en = 1'b0;
         end
         @(posedge clk); #1;
         if (i >= WPR && !c_available && !out_valid) break;
      end
      wr_en     = 1'b0;
      out_ready = 1'b0;
      check("s3_count", 512'(cap_q.size()), 512'(256));
      check("s3_word5", cap_q[5], {256'd5011, 256'd5010});
      check("s3_word255", cap_q[255], {256'd7255, 256'd7254});

      // bank1 completes on the same edge bank0 finishes draining
      cap_q.delete();
      for (int i = 0; i < WPR; i++) drive_write(256'(32'h40000 + i), 256'(32'h50000 + i));
      for (int i = 0; i < WPR-1; i++) drive_write(256'(32'h60000 + i), 256'(32'h70000 + i));
      for (int i = 0; i < NR*WPR/2 - 1; i++) handshake_one("s4_hs");
      wait_valid("s4_last_valid");
      out_ready = 1'b1;
      wr_en     = 1'b1;
      data_in   = {256'(32'h70000 + WPR - 1), 256'(32'h60000 + WPR - 1)};
      @(posedge clk); #1;
      out_ready = 1'b0;
      wr_en     = 1'b0;
      check("s4_c_avail", c_available, 1'b1);
      check("s4_not_full", drain_c_full, 1'b0);
      check("s4_count_a", 512'(cap_q.size()), 512'(256));
      out_ready = 1'b1;
      wait_idle("s4_drain", 3000);
      check("s4_count_b", 512'(cap_q.size()), 512'(512));
      check("s4_b_last", cap_q[511], {256'(32'h70000 + 255), 256'(32'h70000 + 254)});

      // reset while holding a word mid-bank, with a partial second block
      cap_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < WPR; i++) drive_write(256'(32'h80000 + i), 256'(32'h90000 + i));
      for (int i = 0; i < 10; i++) drive_write(256'(32'hC0000 + i), 256'(32'hD0000 + i));
      for (int i = 0; i < 3; i++) handshake_one("s5_hs");
      wait_valid("s5_hold");
      #1;
      reset_n = 1'b0;
      #1;
      check("s5_valid_low", out_valid, 1'b0);
      check("s5_data_zero", data_out, '0);
      check("s5_c_avail", c_available, 1'b0);
      check("s5_full", drain_c_full, 1'b0);
      check("s5_ovf_clear", overflow_err, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      cap_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < WPR; i++) drive_write(256'(32'hA0000 + i), 256'(32'hB0000 + i));
      wait_idle("s5_drain", 3000);
      check("s5_count", 512'(cap_q.size()), 512'(256));
      check("s5_word0", cap_q[0], {256'(32'hA0001), 256'(32'hA0000)});
      check("s5_word128", cap_q[128], {256'(32'hB0001), 256'(32'hB0000)});

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/drain_c_collector.md
DRAIN_C_COLLECTOR -- requirements
Module: drain_c_collector

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 2, number of systolic-array rows draining C results.
REQ-002 SHALL have parameter WORDS_PER_ROW, default 256, 256-bit result words per row per block; power of two, at most 256.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1, strobe for one result word from every row.
REQ-006 SHALL have port data_in, input, NUM_ROWS*256, one result per row; row r occupies bits [(r+1)*256-1 : r*256].
REQ-007 SHALL have port out_ready, input, 1, host write path accepts data_out.
REQ-008 SHALL have port data_out, output, 512, packed C word for the host.
REQ-009 SHALL have port out_valid, output, 1, data_out is valid.
REQ-010 SHALL have port c_available, output, 1, at least one complete block is buffered and not yet drained.
REQ-011 SHALL have port drain_c_full, output, 1, both banks are complete and undrained.
REQ-012 SHALL have port overflow_err, output, 1, sticky flag: a write was dropped.

Function
REQ-013 SHALL buffer each row in its own memory of depth 2*WORDS_PER_ROW, split into banks 0 and 1 (double buffering).
REQ-014 SHALL, on each accepted wr_en, write row r's slice to row r's memory at {wr_bank, wr_counter}.
REQ-015 SHALL, when wr_counter reaches WORDS_PER_ROW-1 with wr_en, clear wr_counter, toggle wr_bank and increment wr_completed (10-bit, wrapping).
REQ-016 SHALL drop wr_en while drain_c_full=1 and set overflow_err; counters and memories stay unchanged.
REQ-017 SHALL compute the occupancy as (wr_completed - rd_completed) modulo 2^10.
REQ-018 SHALL drive c_available=1 when occupancy != 0 and drain_c_full=1 when occupancy == 2; both are combinational from the registered counters.
REQ-019 SHALL use a read FSM with states IDLE, RD_LO, RD_HI, CAP, HOLD.
REQ-020 SHALL step the FSM as follows:
- IDLE -> RD_LO when c_available.
- RD_LO: issue a read of address 2k.
- RD_HI: issue a read of address 2k+1; capture the low half.
- CAP: capture the high half; go to HOLD.
- HOLD: hold out_valid=1.
REQ-021 SHALL set data_out[255:0] from the entry at address 2k and data_out[511:256] from address 2k+1, both from the current rd_row and rd_bank.
REQ-022 SHALL use a RAM read latency of 1 cycle, so out_valid rises 3 cycles after entering RD_LO.
REQ-023 SHALL, in HOLD, keep data_out and out_valid stable until out_ready=1; the transfer completes on the cycle where out_valid && out_ready.
REQ-024 SHALL drain each bank in order: row 0, pairs k=0..WORDS_PER_ROW/2-1, then row 1, and so on; NUM_ROWS*WORDS_PER_ROW/2 output words per bank.
REQ-025 SHALL, on transfer of the last word of a bank, toggle rd_bank, increment rd_completed and go to IDLE; on any other transfer go to RD_LO.
REQ-026 SHALL apply both counter updates when a bank write-completion and a bank drain-completion fall in the same cycle; occupancy is unchanged and no write is dropped.
REQ-027 SHALL let the write side fill the other bank while the read side drains a bank, with no coupling except through occupancy.

Reset
REQ-028 SHALL, on reset_n=0 at any time (including mid-block), asynchronously clear:
- wr_counter, wr_bank, wr_completed, rd_completed, rd_bank, rd_row, k
- data_out=0, out_valid=0, overflow_err=0
- FSM to IDLE
REQ-029 SHALL not reset memory contents; partially written blocks are discarded by the counter reset.
REQ-030 SHALL recognise writes from the first clk edge after reset_n deasserts.

Structure
REQ-031 SHALL take the 256 and 512 data widths, the 10-bit completion counter width and the FSM state enum from package sgemm_pkg.
REQ-032 SHALL instantiate one sub-module per row, drain_ram_256x512: simple dual-port RAM, 256-bit, depth 512, registered read with rden, 1-cycle latency.
REQ-033 SHALL register per-row write controls once before the RAM, giving 1-cycle write latency.

Verification
REQ-034 SHALL cover this scenario: 256 wr_en cycles, row0=i, row1=1000+i, out_ready=1 -> 256 words; word0={1,0}, word127={255,254}, word128={1001,1000}; rd_completed=1; c_available=0 after.
REQ-035 SHALL cover this scenario: 512 writes with out_ready=0 -> drain_c_full=1 after write 512; write 513 dropped; overflow_err=1; wr_completed stays 2.
REQ-036 SHALL cover this scenario: out_ready toggled randomly -> data_out stable while out_valid && !out_ready; no word lost or duplicated over 256 words.
REQ-037 SHALL cover this scenario: bank1 last write in the same cycle as bank0 last transfer -> occupancy stays 1; c_available=1; drain_c_full=0.
REQ-038 SHALL cover this scenario: reset_n pulsed low in HOLD mid-bank -> out_valid=0 immediately; all counters 0; a next full block drains from word0 correctly.
